// File: rtl/cu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cu_sequencer_pkg
//   Shared definitions for the ARM control-unit sequencer: state encodings,
//   IR field positions, opcode classes and a small state-class helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package cu_sequencer_pkg;

  // Width of the internal state encoding. The State output is zero-extended
  // from this to STATE_W, so STATE_W must be at least ST_W.
  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_START      = 4'd0,
    ST_FETCH_ADDR = 4'd1,
    ST_FETCH_REQ  = 4'd2,
    ST_FETCH_WAIT = 4'd3,
    ST_DECODE     = 4'd4,
    ST_EXEC_DP    = 4'd5,
    ST_BRANCH     = 4'd6,
    ST_ADDR_CALC  = 4'd7,
    ST_MEM_REQ    = 4'd8,
    ST_MEM_WAIT   = 4'd9,
    ST_WB         = 4'd10,
    ST_FAULT      = 4'd11
  } state_t;

  // IR field positions
  localparam int IR_COND_HI = 31;
  localparam int IR_COND_LO = 28;
  localparam int IR_OPC_HI  = 27;
  localparam int IR_OPC_LO  = 25;
  localparam int IR_P       = 24;   // 1 = pre-index, 0 = post-index
  localparam int IR_U       = 23;   // 1 = add offset, 0 = subtract
  localparam int IR_W       = 21;   // writeback for pre-index
  localparam int IR_L       = 20;   // 1 = load, 0 = store

  // Opcode classes in IR[27:25]
  localparam logic [2:0] OPC_DP_REG = 3'b000;
  localparam logic [2:0] OPC_DP_IMM = 3'b001;
  localparam logic [2:0] OPC_LS_IMM = 3'b010;
  localparam logic [2:0] OPC_LS_REG = 3'b011;
  localparam logic [2:0] OPC_BRANCH = 3'b101;

  // States in which the sequencer waits for MOC (timeout counter active)
  function automatic logic is_wait(input state_t s);
    return (s == ST_FETCH_WAIT) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cu_sequencer_if
//   Bundles the sequencer's inputs (IR, Cond, Moc) and its control-word
//   outputs toward the datapath.
//   master : the sequencer side (drives State and all strobes)
//   slave  : the IR/condition/memory/datapath side (drives IR, Cond, Moc)
// -----------------------------------------------------------------------------
interface cu_sequencer_if #(
  parameter int STATE_W = 6
);
  logic [31:0]        IR;
  logic               Cond;
  logic               Moc;
  logic [STATE_W-1:0] State;
  logic               Mfa;
  logic               Rw;
  logic               IrLd;
  logic               PcLd;
  logic               MarLd;
  logic               MdrLd;
  logic               RfLd;
  logic               PcInc;
  logic               AddrSel;
  logic               AluAdd;
  logic               BaseWb;
  logic               Fault;

  modport master (
    input  IR, Cond, Moc,
    output State, Mfa, Rw, IrLd, PcLd, MarLd, MdrLd, RfLd, PcInc,
           AddrSel, AluAdd, BaseWb, Fault
  );

  modport slave (
    output IR, Cond, Moc,
    input  State, Mfa, Rw, IrLd, PcLd, MarLd, MdrLd, RfLd, PcInc,
           AddrSel, AluAdd, BaseWb, Fault
  );
endinterface

// File: rtl/cu_sequencer_state_reg.sv
// -----------------------------------------------------------------------------
// cu_sequencer_state_reg
//   W-bit state register with asynchronous active-low clear to RST_VAL.
//   Ports: Clk (rising edge), Reset (async, active low), d (next state),
//          q (current state).
// -----------------------------------------------------------------------------
module cu_sequencer_state_reg #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/cu_sequencer.sv
// -----------------------------------------------------------------------------
// cu_sequencer
//   Multi-cycle fetch/decode/execute control sequencer for the ARM datapath.
//   Moore outputs (function of state, qualified by the stable IR fields),
//   full MOC handshake with optional timeout into a sticky FAULT state, and
//   load/store addressing (pre/post index, up/down, base writeback).
//   Ports:
//     Clk    rising-edge clock
//     Reset  asynchronous active-low reset
//     bus    cu_sequencer_if.master: IR, Cond, Moc in; State and the
//            control strobes (Mfa, Rw, IrLd, PcLd, MarLd, MdrLd, RfLd,
//            PcInc, AddrSel, AluAdd, BaseWb, Fault) out
//   Parameters:
//     STATE_W      State output width (>= 4)
//     MOC_TIMEOUT  wait cycles before FAULT; 0 disables the timeout
//     WB_EN        1 honours base writeback, 0 suppresses it
// -----------------------------------------------------------------------------
module cu_sequencer
  import cu_sequencer_pkg::*;
#(
  parameter int STATE_W     = 6,
  parameter int MOC_TIMEOUT = 15,
  parameter int WB_EN       = 1
) (
  input  logic            Clk,
  input  logic            Reset,
  cu_sequencer_if.master  bus
);

  localparam bit         TIMEOUT_ON = (MOC_TIMEOUT != 0);
  localparam int         CNT_W      = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'((MOC_TIMEOUT > 0) ? (MOC_TIMEOUT - 1) : 0);

  state_t            st;
  state_t            nxt;
  logic [ST_W-1:0]   st_q;
  logic [CNT_W-1:0]  cnt;
  logic              expired;

  // IR fields; IR is stable from DECODE until the next fetch completes
  logic [2:0] opc;
  logic       ir_p;
  logic       ir_u;
  logic       ir_w;
  logic       ir_l;
  logic       unused_ir;

  assign opc  = bus.IR[IR_OPC_HI:IR_OPC_LO];
  assign ir_p = bus.IR[IR_P];
  assign ir_u = bus.IR[IR_U];
  assign ir_w = bus.IR[IR_W];
  assign ir_l = bus.IR[IR_L];
  // Condition field is evaluated externally (Cond); B bit and offset
  // fields belong to the datapath.
  assign unused_ir = ^{bus.IR[IR_COND_HI:IR_COND_LO], bus.IR[22], bus.IR[19:0]};

  cu_sequencer_state_reg #(
    .W       (ST_W),
    .RST_VAL (ST_START)
  ) u_state_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (nxt),
    .q     (st_q)
  );

  assign st = state_t'(st_q);

  // Timeout counter: held at zero outside the wait states, so it is zero on
  // entry to each wait; counts Moc-low cycles while waiting.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      cnt <= '0;
    else if (TIMEOUT_ON && is_wait(st) && !bus.Moc)
      cnt <= cnt + CNT_W'(1);
    else
      cnt <= '0;
  end

  assign expired = TIMEOUT_ON && (cnt == LIMIT);

  // Next-state decode. In the wait states Moc is tested before expiry so a
  // completion on the last allowed cycle still progresses normally.
  always_comb begin
    nxt = st;
    case (st)
      ST_START:      nxt = ST_FETCH_ADDR;
      ST_FETCH_ADDR: nxt = ST_FETCH_REQ;
      ST_FETCH_REQ:  nxt = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        if (bus.Moc)      nxt = ST_DECODE;
        else if (expired) nxt = ST_FAULT;
      end
      ST_DECODE: begin
        if (!bus.Cond) begin
          nxt = ST_FETCH_ADDR;
        end else begin
          case (opc)
            OPC_DP_REG, OPC_DP_IMM: nxt = ST_EXEC_DP;
            OPC_BRANCH:             nxt = ST_BRANCH;
            OPC_LS_IMM, OPC_LS_REG: nxt = ST_ADDR_CALC;
            default:                nxt = ST_FETCH_ADDR;
          endcase
        end
      end
      ST_EXEC_DP:    nxt = ST_FETCH_ADDR;
      ST_BRANCH:     nxt = ST_FETCH_ADDR;
      ST_ADDR_CALC:  nxt = ST_MEM_REQ;
      ST_MEM_REQ:    nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: begin
        if (bus.Moc)      nxt = ST_WB;
        else if (expired) nxt = ST_FAULT;
      end
      ST_WB:         nxt = ST_FETCH_ADDR;
      ST_FAULT:      nxt = ST_FAULT;
      default:       nxt = ST_START;
    endcase
  end

  // Output encode
  logic mfa, rw, ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, pc_inc;
  logic addr_sel, alu_add, base_wb, fault;

  always_comb begin
    mfa      = 1'b0;
    rw       = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    mar_ld   = 1'b0;
    mdr_ld   = 1'b0;
    rf_ld    = 1'b0;
    pc_inc   = 1'b0;
    addr_sel = 1'b0;
    alu_add  = 1'b0;
    base_wb  = 1'b0;
    fault    = 1'b0;
    case (st)
      ST_FETCH_ADDR: mar_ld = 1'b1;            // MAR <= PC
      ST_FETCH_REQ: begin
        mfa    = 1'b1;
        rw     = 1'b1;
        pc_inc = 1'b1;
      end
      ST_FETCH_WAIT: begin
        // IR keeps reloading while waiting; the load on the Moc cycle wins
        mfa   = 1'b1;
        rw    = 1'b1;
        ir_ld = 1'b1;
      end
      ST_EXEC_DP:    rf_ld = 1'b1;
      ST_BRANCH:     pc_ld = 1'b1;
      ST_ADDR_CALC: begin
        mar_ld   = 1'b1;
        addr_sel = ir_p;                       // pre-index uses Rn +/- offset
        alu_add  = ir_u;
        mdr_ld   = ~ir_l;                      // store: MDR <= Rd
      end
      ST_MEM_REQ: begin
        mfa = 1'b1;
        rw  = ir_l;
      end
      ST_MEM_WAIT: begin
        mfa    = 1'b1;
        rw     = ir_l;
        mdr_ld = ir_l;                         // load: MDR <= memory
      end
      ST_WB: begin
        // Both may be set; the datapath gives the base write priority.
        rf_ld   = ir_l;
        base_wb = (WB_EN != 0) && (!ir_p || ir_w);
      end
      ST_FAULT:      fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.State   = STATE_W'(st_q);
  assign bus.Mfa     = mfa;
  assign bus.Rw      = rw;
  assign bus.IrLd    = ir_ld;
  assign bus.PcLd    = pc_ld;
  assign bus.MarLd   = mar_ld;
  assign bus.MdrLd   = mdr_ld;
  assign bus.RfLd    = rf_ld;
  assign bus.PcInc   = pc_inc;
  assign bus.AddrSel = addr_sel;
  assign bus.AluAdd  = alu_add;
  assign bus.BaseWb  = base_wb;
  assign bus.Fault   = fault;

endmodule

// File: tb/tb_cu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cu_sequencer
//   Drives two sequencers in lockstep from the same IR/Cond/Moc:
//     dut_a: MOC_TIMEOUT=4, WB_EN=1
//     dut_b: MOC_TIMEOUT=0, WB_EN=0
//   For each instruction a per-cycle trace (state + control word + Moc to
//   apply) is derived from the instruction fields and the chosen wait
//   lengths, then compared cycle by cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_cu_sequencer;
  import cu_sequencer_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        Cond = 1'b0;
  logic        Moc = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  cu_sequencer_if #(.STATE_W(6)) ifa ();
  cu_sequencer_if #(.STATE_W(6)) ifb ();

  assign ifa.IR = IR;  assign ifa.Cond = Cond;  assign ifa.Moc = Moc;
  assign ifb.IR = IR;  assign ifb.Cond = Cond;  assign ifb.Moc = Moc;

  cu_sequencer #(.STATE_W(6), .MOC_TIMEOUT(4), .WB_EN(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(ifa.master));
  cu_sequencer #(.STATE_W(6), .MOC_TIMEOUT(0), .WB_EN(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(ifb.master));

  // Control word bit masks
  localparam logic [11:0] O_MFA = 12'h800, O_RW  = 12'h400, O_IRL = 12'h200,
                          O_PCL = 12'h100, O_MAR = 12'h080, O_MDR = 12'h040,
                          O_RFL = 12'h020, O_PCI = 12'h010, O_ASL = 12'h008,
                          O_ALU = 12'h004, O_BWB = 12'h002, O_FLT = 12'h001,
                          O_NONE = 12'h000;

  logic [11:0] oa, ob;
  assign oa = {ifa.Mfa, ifa.Rw, ifa.IrLd, ifa.PcLd, ifa.MarLd, ifa.MdrLd,
               ifa.RfLd, ifa.PcInc, ifa.AddrSel, ifa.AluAdd, ifa.BaseWb, ifa.Fault};
  assign ob = {ifb.Mfa, ifb.Rw, ifb.IrLd, ifb.PcLd, ifb.MarLd, ifb.MdrLd,
               ifb.RfLd, ifb.PcInc, ifb.AddrSel, ifb.AluAdd, ifb.BaseWb, ifb.Fault};

  typedef struct packed {
    logic [3:0]  st;
    logic [11:0] o;     // control word excluding base writeback
    logic        bwb;   // base writeback requested by the instruction
    logic        moc;   // Moc to present during this cycle
  } ent_t;

  ent_t        tq[$];
  logic [31:0] cur_ir;
  logic        cur_cond;

  function automatic void push(input state_t s, input logic [11:0] o,
                               input logic bwb, input logic moc);
    ent_t e;
    e.st = s; e.o = o; e.bwb = bwb; e.moc = moc;
    tq.push_back(e);
  endfunction

  // Trace of one instruction from FETCH_ADDR up to (not including) the next
  // FETCH_ADDR. fw/mw = Moc-low cycles in the fetch/memory wait. With hold
  // set, Moc never rises in the memory wait and the trace stops after mw+1
  // wait cycles.
  task automatic build(input logic [31:0] ir, input logic cond,
                       input int fw, input int mw, input bit hold);
    logic [2:0] opc;
    logic p, u, w, l;
    tq.delete();
    cur_ir = ir; cur_cond = cond;
    opc = ir[27:25]; p = ir[24]; u = ir[23]; w = ir[21]; l = ir[20];
    push(ST_FETCH_ADDR, O_MAR, 1'b0, 1'b0);
    push(ST_FETCH_REQ, O_MFA | O_RW | O_PCI, 1'b0, 1'b0);
    for (int k = 0; k <= fw; k++)
      push(ST_FETCH_WAIT, O_MFA | O_RW | O_IRL, 1'b0, k == fw);
    push(ST_DECODE, O_NONE, 1'b0, 1'b0);
    if (cond) begin
      if (opc == 3'd0 || opc == 3'd1) begin
        push(ST_EXEC_DP, O_RFL, 1'b0, 1'b0);
      end else if (opc == 3'd5) begin
        push(ST_BRANCH, O_PCL, 1'b0, 1'b0);
      end else if (opc == 3'd2 || opc == 3'd3) begin
        push(ST_ADDR_CALC, O_MAR | (p ? O_ASL : O_NONE) | (u ? O_ALU : O_NONE)
                           | (l ? O_NONE : O_MDR), 1'b0, 1'b0);
        push(ST_MEM_REQ, O_MFA | (l ? O_RW : O_NONE), 1'b0, 1'b0);
        for (int k = 0; k <= mw; k++)
          push(ST_MEM_WAIT, O_MFA | (l ? (O_RW | O_MDR) : O_NONE), 1'b0,
               (k == mw) && !hold);
        if (!hold) push(ST_WB, l ? O_RFL : O_NONE, !p || w, 1'b0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s: observed state/ctl %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_both(input string tag, input logic [3:0] st_a,
                             input logic [11:0] o_a, input logic [3:0] st_b,
                             input logic [11:0] o_b);
    chk({tag, "/a"}, {ifa.State, oa}, {2'b00, st_a, o_a});
    chk({tag, "/b"}, {ifb.State, ob}, {2'b00, st_b, o_b});
  endtask

  // Replays the first n entries of the trace (all when n < 0); IR/Cond are
  // changed only once the new fetch is under way.
  task automatic play(input string tag, input int n);
    int lim;
    lim = (n < 0 || n > tq.size()) ? tq.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge Clk);
      expect_both($sformatf("%s[%0d]", tag, i),
                  tq[i].st, tq[i].o | (tq[i].bwb ? O_BWB : O_NONE),
                  tq[i].st, tq[i].o);
      if (i == 0) begin IR = cur_ir; Cond = cur_cond; end
      Moc = tq[i].moc;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ir, input logic cond,
                     input int fw, input int mw);
    build(ir, cond, fw, mw, 1'b0);
    play(tag, -1);
  endtask

  initial begin
    logic [31:0] rir;

    // Reset asserted asynchronously at 3 ns
    #3 Reset = 1'b0;
    @(negedge Clk);
    expect_both("reset", ST_START, O_NONE, ST_START, O_NONE);
    @(negedge Clk);
    expect_both("reset_hold", ST_START, O_NONE, ST_START, O_NONE);
    Reset = 1'b1;

    // Directed instructions
    run("add",      32'hE0810002, 1'b1, 0, 0);
    run("ldr_pre",  32'hE5912004, 1'b1, 1, 3);
    run("str_post", 32'hE4012004, 1'b1, 0, 0);
    run("squash",   32'hE5912004, 1'b0, 2, 0);
    run("branch",   32'hEA000010, 1'b1, 0, 0);
    run("nop",      32'hE8000000, 1'b1, 0, 0);
    run("ldr_wb",   32'hE5B12004, 1'b1, 0, 1);
    run("str_pre",  32'hE5012004, 1'b1, 3, 2);

    // Timeout: Moc stays low in MEM_WAIT. dut_a faults after 4 wait cycles;
    // dut_b (timeout disabled) keeps waiting.
    build(32'hE5912004, 1'b1, 0, 3, 1'b1);
    play("tmo", -1);
    for (int j = 0; j < 5; j++) begin
      @(negedge Clk);
      expect_both($sformatf("fault[%0d]", j), ST_FAULT, O_FLT,
                  ST_MEM_WAIT, O_MFA | O_RW | O_MDR);
      Moc = (j == 4);
    end
    @(negedge Clk);
    expect_both("fault_sticky", ST_FAULT, O_FLT, ST_WB, O_RFL);
    Moc = 1'b0;
    @(negedge Clk);
    expect_both("fault_sticky2", ST_FAULT, O_FLT, ST_FETCH_ADDR, O_MAR);
    #2 Reset = 1'b0;
    #1 expect_both("fault_clear", ST_START, O_NONE, ST_START, O_NONE);
    @(negedge Clk);
    Reset = 1'b1;

    run("after_fault", 32'hE0810002, 1'b1, 0, 0);

    // Reset in the middle of a fetch wait aborts it; Mfa drops at once
    build(32'hE0810002, 1'b1, 2, 0, 1'b0);
    play("abort", 3);
    #2 Reset = 1'b0;
    #1 expect_both("abort_rst", ST_START, O_NONE, ST_START, O_NONE);
    @(negedge Clk);
    expect_both("abort_hold", ST_START, O_NONE, ST_START, O_NONE);
    Reset = 1'b1;
    Moc = 1'b0;

    // Random instruction mix; waits kept below the dut_a timeout
    for (int n = 0; n < 60; n++) begin
      rir = $urandom;
      run($sformatf("rnd%0d", n), rir, ($urandom_range(0, 3) != 0),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
